// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/completion bus between the two caches, the byte
// controller and the single-port 8-bit RAM/IO bus.
//   slave  : controller view (requests and mem_din in; grants, completions out)
//   master : environment view (caches plus RAM/IO), the mirror of slave
interface mem_ctrl_if #(
   parameter int ADDR_WIDTH = 18
);
   logic                  dcache_get_en;
   logic                  dcache_write_mode;
   logic [ADDR_WIDTH-1:0] dcache_addr;
   logic [7:0]            dcache_data;
   logic                  dcache_out_en;
   logic [7:0]            dcache_content;

   logic                  icache_get_en;
   logic [ADDR_WIDTH-1:0] icache_addr;
   logic                  icache_out_en;
   logic [7:0]            icache_content;

   logic                  io_buffer_full;
   logic [7:0]            mem_din;
   logic [7:0]            mem_dout;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic                  mem_wr;

   modport slave (
      input  dcache_get_en, dcache_write_mode, dcache_addr, dcache_data,
      output dcache_out_en, dcache_content,
      input  icache_get_en, icache_addr,
      output icache_out_en, icache_content,
      input  io_buffer_full, mem_din,
      output mem_dout, mem_a, mem_wr
   );

   modport master (
      output dcache_get_en, dcache_write_mode, dcache_addr, dcache_data,
      input  dcache_out_en, dcache_content,
      output icache_get_en, icache_addr,
      input  icache_out_en, icache_content,
      output io_buffer_full, mem_din,
      input  mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial arbiter placing one dcache or icache byte per cycle on
// the RAM/IO bus, with a one-cycle completion pulse back to the issuer.
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset
//   bus    - mem_ctrl_if.slave (cache requests/completions, RAM/IO bus)
//
// state     | meaning
// ----------+---------------------------------------------------------
// OWN_NONE  | nothing issued last cycle, no completion due
// OWN_D     | dcache byte issued last cycle, dcache_out_en this cycle
// OWN_I     | icache byte issued last cycle, icache_out_en this cycle
module mem_ctrl #(
   parameter int         ADDR_WIDTH = 18,
   parameter logic [1:0] IO_PREFIX  = 2'b11
) (
   input  logic        clk,
   input  logic        rst_n,
   mem_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_D    = 2'd1,
      OWN_I    = 2'd2
   } owner_e;

   owner_e r_owner;
   owner_e w_grant;
   logic   w_dcache_blocked;

   // An IO write cannot proceed while the IO buffer is full; the cycle is
   // handed to the icache instead and the dcache retries next cycle.
   assign w_dcache_blocked = bus.dcache_get_en & bus.dcache_write_mode &
                             (bus.dcache_addr[ADDR_WIDTH-1 -: 2] == IO_PREFIX) &
                             bus.io_buffer_full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner <= OWN_NONE;
      end else begin
         r_owner <= w_grant;
      end
   end

   // Next state is the current cycle's grant; reset suppresses any grant.
   always_comb begin
      w_grant = OWN_NONE;
      if (rst_n) begin
         if (bus.dcache_get_en && !w_dcache_blocked) begin
            w_grant = OWN_D;
         end else if (bus.icache_get_en) begin
            w_grant = OWN_I;
         end
      end
   end

   // Completions are gated by rst_n so a byte issued just before reset
   // never produces a pulse.
   always_comb begin
      bus.mem_a          = '0;
      bus.mem_wr         = 1'b0;
      bus.mem_dout       = 8'h00;
      bus.dcache_out_en  = rst_n && (r_owner == OWN_D);
      bus.icache_out_en  = rst_n && (r_owner == OWN_I);
      bus.dcache_content = bus.mem_din;
      bus.icache_content = bus.mem_din;
      case (w_grant)
         OWN_D: begin
            bus.mem_a    = bus.dcache_addr;
            bus.mem_wr   = bus.dcache_write_mode;
            bus.mem_dout = bus.dcache_data;
         end
         OWN_I: begin
            bus.mem_a    = bus.icache_addr;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a one-cycle-latency RAM model.
module tb_mem_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   mem_ctrl_if #(.ADDR_WIDTH(18)) bus ();

   mem_ctrl #(.ADDR_WIDTH(18), .IO_PREFIX(2'b11)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // RAM model: preload pattern, overridden by any written byte. IO space
   // writes are not stored. Read data appears one cycle after the address.
   logic [7:0] wram   [0:4095];
   bit         wvalid [0:4095];
   bit  [11:0] rd_addr;

   function automatic logic [7:0] init_val(input bit [11:0] a);
      if (a >= 12'h100 && a <= 12'h103) return 8'h11 * 8'(a - 12'h100 + 1);
      if (a < 12'h010) return 8'hA0 + 8'(a);
      return 8'h00;
   endfunction

   always @(posedge clk) begin
      if (bus.mem_wr && bus.mem_a[17:16] != 2'b11) begin
         wram[bus.mem_a[11:0]]   <= bus.mem_dout;
         wvalid[bus.mem_a[11:0]] <= 1'b1;
      end
      rd_addr <= bus.mem_a[11:0];
   end

   assign bus.mem_din = wvalid[rd_addr] ? wram[rd_addr] : init_val(rd_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Interleave script: icache streams 0x008..0x00F, dcache reads 0x100/0x101.
   int t_ig  [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
   int t_ia  [12] = '{8, 9, 10, 10, 10, 11, 12, 13, 14, 15, 0, 0};
   int t_dg  [12] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
   int t_da  [12] = '{0, 0, 'h100, 'h101, 0, 0, 0, 0, 0, 0, 0, 0};
   int t_ma  [12] = '{8, 9, 'h100, 'h101, 10, 11, 12, 13, 14, 15, 0, 0};
   int t_ed  [12] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
   int t_ei  [12] = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0};
   int t_dat [12] = '{0, 'hA8, 'hA9, 'h11, 'h22, 'hAA, 'hAB, 'hAC, 'hAD, 'hAE, 'hAF, 0};

   initial begin
      bus.dcache_get_en     = 1'b1;
      bus.dcache_write_mode = 1'b0;
      bus.dcache_addr       = 18'h00100;
      bus.dcache_data       = 8'h00;
      bus.icache_get_en     = 1'b1;
      bus.icache_addr       = 18'h00005;
      bus.io_buffer_full    = 1'b0;
      rst_n                 = 1'b0;

      // Reset held 3 cycles with both requesters active.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_mem_wr", 32'(bus.mem_wr), 0);
         chk("rst_mem_a", 32'(bus.mem_a), 0);
         chk("rst_d_out_en", 32'(bus.dcache_out_en), 0);
         chk("rst_i_out_en", 32'(bus.icache_out_en), 0);
         next_cycle();
      end

      // Release: dcache burst 0x100..0x103, first grant in release cycle.
      rst_n             = 1'b1;
      bus.icache_get_en = 1'b0;
      @(negedge clk);
      chk("burst0_mem_a", 32'(bus.mem_a), 32'h100);
      chk("burst0_d_out_en", 32'(bus.dcache_out_en), 0);
      next_cycle();
      for (int i = 1; i < 4; i++) begin
         bus.dcache_addr = 18'h00100 + 18'(i);
         @(negedge clk);
         chk("burst_mem_a", 32'(bus.mem_a), 32'h100 + 32'(i));
         chk("burst_d_out_en", 32'(bus.dcache_out_en), 1);
         chk("burst_content", 32'(bus.dcache_content), 32'h11 * 32'(i));
         next_cycle();
      end
      bus.dcache_get_en = 1'b0;
      @(negedge clk);
      chk("burst4_d_out_en", 32'(bus.dcache_out_en), 1);
      chk("burst4_content", 32'(bus.dcache_content), 32'h44);
      chk("burst4_idle_mem_a", 32'(bus.mem_a), 0);
      next_cycle();
      @(negedge clk);
      chk("idle_d_out_en", 32'(bus.dcache_out_en), 0);
      chk("idle_i_out_en", 32'(bus.icache_out_en), 0);
      next_cycle();

      // Simultaneous dcache write and icache read: dcache wins.
      bus.icache_get_en     = 1'b1;
      bus.icache_addr       = 18'h00000;
      bus.dcache_get_en     = 1'b1;
      bus.dcache_write_mode = 1'b1;
      bus.dcache_addr       = 18'h00200;
      bus.dcache_data       = 8'hAB;
      @(negedge clk);
      chk("sim_mem_wr", 32'(bus.mem_wr), 1);
      chk("sim_mem_a", 32'(bus.mem_a), 32'h200);
      chk("sim_mem_dout", 32'(bus.mem_dout), 32'hAB);
      next_cycle();
      bus.dcache_get_en     = 1'b0;
      bus.dcache_write_mode = 1'b0;
      @(negedge clk);
      chk("sim_d_ack", 32'(bus.dcache_out_en), 1);
      chk("sim_i_not_yet", 32'(bus.icache_out_en), 0);
      chk("sim_i_grant_a", 32'(bus.mem_a), 0);
      chk("sim_i_grant_wr", 32'(bus.mem_wr), 0);
      chk("sim_i_grant_dout", 32'(bus.mem_dout), 0);
      next_cycle();
      // Read-after-write on the dcache side while the icache completes.
      bus.icache_get_en = 1'b0;
      bus.dcache_get_en = 1'b1;
      bus.dcache_addr   = 18'h00200;
      @(negedge clk);
      chk("sim_i_out_en", 32'(bus.icache_out_en), 1);
      chk("sim_d_no_out", 32'(bus.dcache_out_en), 0);
      chk("sim_i_content", 32'(bus.icache_content), 32'hA0);
      chk("raw_mem_a", 32'(bus.mem_a), 32'h200);
      next_cycle();
      bus.dcache_get_en = 1'b0;
      @(negedge clk);
      chk("raw_d_out_en", 32'(bus.dcache_out_en), 1);
      chk("raw_content", 32'(bus.dcache_content), 32'hAB);
      next_cycle();

      // Blocked IO write yields to an icache stream.
      bus.dcache_get_en     = 1'b1;
      bus.dcache_write_mode = 1'b1;
      bus.dcache_addr       = 18'h30000;
      bus.dcache_data       = 8'h5A;
      bus.io_buffer_full    = 1'b1;
      bus.icache_get_en     = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.icache_addr = 18'(1 + i);
         @(negedge clk);
         chk("io_blk_mem_wr", 32'(bus.mem_wr), 0);
         chk("io_blk_mem_a", 32'(bus.mem_a), 32'(1 + i));
         chk("io_blk_d_out_en", 32'(bus.dcache_out_en), 0);
         if (i > 0) begin
            chk("io_blk_i_out_en", 32'(bus.icache_out_en), 1);
            chk("io_blk_i_content", 32'(bus.icache_content), 32'hA0 + 32'(i));
         end
         next_cycle();
      end
      bus.io_buffer_full = 1'b0;
      bus.icache_addr    = 18'h00006;
      @(negedge clk);
      chk("io_go_mem_wr", 32'(bus.mem_wr), 1);
      chk("io_go_mem_a", 32'(bus.mem_a), 32'h30000);
      chk("io_go_mem_dout", 32'(bus.mem_dout), 32'h5A);
      chk("io_go_i_out_en", 32'(bus.icache_out_en), 1);
      chk("io_go_i_content", 32'(bus.icache_content), 32'hA5);
      next_cycle();
      bus.dcache_get_en     = 1'b0;
      bus.dcache_write_mode = 1'b0;
      @(negedge clk);
      chk("io_ack_d_out_en", 32'(bus.dcache_out_en), 1);
      chk("io_ack_i_out_en", 32'(bus.icache_out_en), 0);
      chk("io_ack_mem_a", 32'(bus.mem_a), 6);
      next_cycle();
      bus.icache_get_en = 1'b0;
      @(negedge clk);
      chk("io_tail_i_out_en", 32'(bus.icache_out_en), 1);
      chk("io_tail_i_content", 32'(bus.icache_content), 32'hA6);
      next_cycle();

      // Interleave: two dcache reads injected into an 8-byte icache stream.
      for (int t = 0; t < 12; t++) begin
         bus.icache_get_en = t_ig[t][0];
         bus.icache_addr   = 18'(t_ia[t]);
         bus.dcache_get_en = t_dg[t][0];
         bus.dcache_addr   = 18'(t_da[t]);
         @(negedge clk);
         chk("ilv_mem_a", 32'(bus.mem_a), 32'(t_ma[t]));
         chk("ilv_d_out_en", 32'(bus.dcache_out_en), 32'(t_ed[t]));
         chk("ilv_i_out_en", 32'(bus.icache_out_en), 32'(t_ei[t]));
         if (t_ed[t] != 0) chk("ilv_d_content", 32'(bus.dcache_content), 32'(t_dat[t]));
         if (t_ei[t] != 0) chk("ilv_i_content", 32'(bus.icache_content), 32'(t_dat[t]));
         next_cycle();
      end

      // Reset the cycle after a dcache read grant: completion is dropped.
      bus.dcache_get_en = 1'b1;
      bus.dcache_addr   = 18'h00102;
      @(negedge clk);
      chk("rstm_grant_a", 32'(bus.mem_a), 32'h102);
      next_cycle();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstm_d_out_en", 32'(bus.dcache_out_en), 0);
      chk("rstm_mem_a", 32'(bus.mem_a), 0);
      chk("rstm_mem_wr", 32'(bus.mem_wr), 0);
      next_cycle();
      rst_n             = 1'b1;
      bus.dcache_get_en = 1'b0;
      @(negedge clk);
      chk("rstm_after_d", 32'(bus.dcache_out_en), 0);
      chk("rstm_after_i", 32'(bus.icache_out_en), 0);
      next_cycle();
      @(negedge clk);
      chk("rstm_idle_d", 32'(bus.dcache_out_en), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
